// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: NUM_CH write channels, 2-entry skid buffer, flush and same-destination masking.
// Optional back-pressure stall counter on stall_cnt, enabled by defining MEM_WB_STALL_CNT_EN.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
  input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
  input  logic [NUM_CH-1:0]        mem_wreg,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [NUM_CH*ADDR_W-1:0] wb_wd,
  output logic [NUM_CH*DATA_W-1:0] wb_wdata,
  output logic [NUM_CH-1:0]        wb_wreg
`ifdef MEM_WB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt
`endif
);

  if (NUM_CH < 1 || NUM_CH > 4 || CNT_W < 1) begin : gParamCheck
    $error("mem_wb_pipe: NUM_CH must be 1..4 and CNT_W at least 1");
  end

  logic                     mainValid_q, mainValid_d;
  logic [NUM_CH*ADDR_W-1:0] mainWd_q, mainWd_d;
  logic [NUM_CH*DATA_W-1:0] mainWdata_q, mainWdata_d;
  logic [NUM_CH-1:0]        mainWreg_q, mainWreg_d;

  logic                     skidValid_q, skidValid_d;
  logic [NUM_CH*ADDR_W-1:0] skidWd_q, skidWd_d;
  logic [NUM_CH*DATA_W-1:0] skidWdata_q, skidWdata_d;
  logic [NUM_CH-1:0]        skidWreg_q, skidWreg_d;

  logic              accept;
  logic              consume;
  logic [NUM_CH-1:0] memWregMasked;

  assign mem_ready = !skidValid_q;
  assign accept    = mem_valid && mem_ready && !flush;
  assign consume   = mainValid_q && wb_ready;

  // An older channel loses its write enable when a younger channel writes the same register.
  always_comb begin
    memWregMasked = mem_wreg;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = i + 1; j < NUM_CH; j++) begin
        if (mem_wreg[i] && mem_wreg[j] &&
            (mem_wd[i*ADDR_W +: ADDR_W] == mem_wd[j*ADDR_W +: ADDR_W])) begin
          memWregMasked[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    mainValid_d = mainValid_q;
    mainWd_d    = mainWd_q;
    mainWdata_d = mainWdata_q;
    mainWreg_d  = mainWreg_q;
    skidValid_d = skidValid_q;
    skidWd_d    = skidWd_q;
    skidWdata_d = skidWdata_q;
    skidWreg_d  = skidWreg_q;

    if (flush) begin
      mainValid_d = 1'b0;
      mainWreg_d  = '0;
      skidValid_d = 1'b0;
      skidWreg_d  = '0;
    end else if (!mainValid_q || consume) begin
      if (skidValid_q) begin
        mainValid_d = 1'b1;
        mainWd_d    = skidWd_q;
        mainWdata_d = skidWdata_q;
        mainWreg_d  = skidWreg_q;
        if (accept) begin
          skidWd_d    = mem_wd;
          skidWdata_d = mem_wdata;
          skidWreg_d  = memWregMasked;
        end else begin
          skidValid_d = 1'b0;
          skidWreg_d  = '0;
        end
      end else if (accept) begin
        mainValid_d = 1'b1;
        mainWd_d    = mem_wd;
        mainWdata_d = mem_wdata;
        mainWreg_d  = memWregMasked;
      end else begin
        mainValid_d = 1'b0;
        mainWreg_d  = '0;
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skidWd_d    = mem_wd;
      skidWdata_d = mem_wdata;
      skidWreg_d  = memWregMasked;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mainValid_q <= 1'b0;
      mainWd_q    <= '0;
      mainWdata_q <= '0;
      mainWreg_q  <= '0;
      skidValid_q <= 1'b0;
      skidWd_q    <= '0;
      skidWdata_q <= '0;
      skidWreg_q  <= '0;
    end else begin
      mainValid_q <= mainValid_d;
      mainWd_q    <= mainWd_d;
      mainWdata_q <= mainWdata_d;
      mainWreg_q  <= mainWreg_d;
      skidValid_q <= skidValid_d;
      skidWd_q    <= skidWd_d;
      skidWdata_q <= skidWdata_d;
      skidWreg_q  <= skidWreg_d;
    end
  end

  assign wb_valid = mainValid_q;
  assign wb_wd    = mainWd_q;
  assign wb_wdata = mainWdata_q;
  assign wb_wreg  = mainWreg_q & {NUM_CH{mainValid_q}};

`ifdef MEM_WB_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt_q;

  // Saturating count of cycles where MEM offers an entry but the skid slot is occupied; flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt_q <= '0;
    end else if (mem_valid && !mem_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_q <= stallCnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: vector table for streaming, masking, back-pressure and flush,
// plus hand sequences for async reset mid-stall and (with MEM_WB_STALL_CNT_EN) the stall counter.
module tb_mem_wb_pipe;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 4;
  localparam int WD_W    = NUM_CH * ADDR_W;
  localparam int WDATA_W = NUM_CH * DATA_W;

  typedef struct {
    logic               flush;
    logic               memValid;
    logic               wbReady;
    logic [WD_W-1:0]    wd;
    logic [WDATA_W-1:0] wdata;
    logic [NUM_CH-1:0]  wreg;
    logic               expValid;
    logic               expReady;
    logic [WD_W-1:0]    expWd;
    logic [WDATA_W-1:0] expWdata;
    logic [NUM_CH-1:0]  expWreg;
    logic               chkData;
  } vec_t;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               memValid;
  logic               memReady;
  logic [WD_W-1:0]    memWd;
  logic [WDATA_W-1:0] memWdata;
  logic [NUM_CH-1:0]  memWreg;
  logic               wbValid;
  logic               wbReady;
  logic [WD_W-1:0]    wbWd;
  logic [WDATA_W-1:0] wbWdata;
  logic [NUM_CH-1:0]  wbWreg;
`ifdef MEM_WB_STALL_CNT_EN
  logic [CNT_W-1:0]   stallCnt;
`endif

  int   total;
  int   bad;
  vec_t vecs[$];

  mem_wb_pipe #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .mem_valid(memValid),
    .mem_ready(memReady),
    .mem_wd   (memWd),
    .mem_wdata(memWdata),
    .mem_wreg (memWreg),
    .wb_valid (wbValid),
    .wb_ready (wbReady),
    .wb_wd    (wbWd),
    .wb_wdata (wbWdata),
    .wb_wreg  (wbWreg)
`ifdef MEM_WB_STALL_CNT_EN
    ,
    .stall_cnt(stallCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic f, input logic mv, input logic rdy,
                        input logic [WD_W-1:0] wd, input logic [WDATA_W-1:0] wdata,
                        input logic [NUM_CH-1:0] wreg, input logic eV, input logic eR,
                        input logic [WD_W-1:0] eWd, input logic [WDATA_W-1:0] eWdata,
                        input logic [NUM_CH-1:0] eWreg, input logic chk);
    vec_t v;
    v.flush = f;      v.memValid = mv;  v.wbReady = rdy;
    v.wd = wd;        v.wdata = wdata;  v.wreg = wreg;
    v.expValid = eV;  v.expReady = eR;  v.expWd = eWd;
    v.expWdata = eWdata; v.expWreg = eWreg; v.chkData = chk;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic f, input logic mv, input logic rdy,
                               input logic [WD_W-1:0] wd, input logic [WDATA_W-1:0] wdata,
                               input logic [NUM_CH-1:0] wreg);
    @(negedge clk);
    flush    = f;
    memValid = mv;
    wbReady  = rdy;
    memWd    = wd;
    memWdata = wdata;
    memWreg  = wreg;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkVal($sformatf("v%0d wb_valid", idx), 64'(wbValid), 64'(v.expValid));
    checkVal($sformatf("v%0d mem_ready", idx), 64'(memReady), 64'(v.expReady));
    checkVal($sformatf("v%0d wb_wreg", idx), 64'(wbWreg), 64'(v.expWreg));
    if (v.chkData) begin
      checkVal($sformatf("v%0d wb_wd", idx), 64'(wbWd), 64'(v.expWd));
      checkVal($sformatf("v%0d wb_wdata", idx), wbWdata, v.expWdata);
    end
  endtask

  localparam logic [WD_W-1:0]    WD_A = {5'd1, 5'd9};
  localparam logic [WDATA_W-1:0] DA_A = {32'hA1, 32'hA0};
  localparam logic [WD_W-1:0]    WD_B = {5'd3, 5'd2};
  localparam logic [WDATA_W-1:0] DA_B = {32'hB1, 32'hB0};
  localparam logic [WD_W-1:0]    WD_C = {5'd5, 5'd4};
  localparam logic [WDATA_W-1:0] DA_C = {32'hC1, 32'hC0};
  localparam logic [WD_W-1:0]    WD_D = {5'd6, 5'd6};
  localparam logic [WDATA_W-1:0] DA_D = {32'hD1, 32'hD0};
  localparam logic [WD_W-1:0]    WD_E = {5'd9, 5'd8};
  localparam logic [WDATA_W-1:0] DA_E = {32'hE1, 32'hE0};
  localparam logic [WD_W-1:0]    WD_F = {5'd10, 5'd11};
  localparam logic [WDATA_W-1:0] DA_F = {32'hF1, 32'hF0};

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    flush    = 1'b0;
    memValid = 1'b0;
    wbReady  = 1'b0;
    memWd    = '0;
    memWdata = '0;
    memWreg  = '0;

    // Streaming: four back-to-back entries, then same-destination masking cases.
    addVec(0, 1, 1, {5'd2, 5'd1}, {32'hB, 32'hA}, 2'b11, 1, 1, {5'd2, 5'd1}, {32'hB, 32'hA}, 2'b11, 1);
    addVec(0, 1, 1, {5'd4, 5'd3}, {32'hD, 32'hC}, 2'b11, 1, 1, {5'd4, 5'd3}, {32'hD, 32'hC}, 2'b11, 1);
    addVec(0, 1, 1, {5'd6, 5'd5}, {32'hF, 32'hE}, 2'b01, 1, 1, {5'd6, 5'd5}, {32'hF, 32'hE}, 2'b01, 1);
    addVec(0, 1, 1, {5'd8, 5'd7}, {32'h11, 32'h10}, 2'b10, 1, 1, {5'd8, 5'd7}, {32'h11, 32'h10}, 2'b10, 1);
    addVec(0, 1, 1, {5'd7, 5'd7}, {32'h22, 32'h11}, 2'b11, 1, 1, {5'd7, 5'd7}, {32'h22, 32'h11}, 2'b10, 1);
    addVec(0, 1, 1, {5'd7, 5'd8}, {32'h22, 32'h11}, 2'b11, 1, 1, {5'd7, 5'd8}, {32'h22, 32'h11}, 2'b11, 1);
    addVec(0, 1, 1, {5'd7, 5'd7}, {32'h33, 32'h44}, 2'b01, 1, 1, {5'd7, 5'd7}, {32'h33, 32'h44}, 2'b01, 1);
    addVec(0, 0, 1, '0, '0, 2'b00, 0, 1, '0, '0, 2'b00, 0);
    // Back-pressure: A in main, B in skid, C refused until WB drains in order.
    addVec(0, 1, 0, WD_A, DA_A, 2'b11, 1, 1, WD_A, DA_A, 2'b11, 1);
    addVec(0, 1, 0, WD_B, DA_B, 2'b11, 1, 0, WD_A, DA_A, 2'b11, 1);
    addVec(0, 1, 0, WD_C, DA_C, 2'b11, 1, 0, WD_A, DA_A, 2'b11, 1);
    addVec(0, 1, 1, WD_C, DA_C, 2'b11, 1, 1, WD_B, DA_B, 2'b11, 1);
    addVec(0, 1, 1, WD_C, DA_C, 2'b11, 1, 1, WD_C, DA_C, 2'b11, 1);
    addVec(0, 0, 1, '0, '0, 2'b00, 0, 1, '0, '0, 2'b00, 0);
    // Flush while full with a new entry offered; F must never surface.
    addVec(0, 1, 0, WD_D, DA_D, 2'b11, 1, 1, WD_D, DA_D, 2'b10, 1);
    addVec(0, 1, 0, WD_E, DA_E, 2'b11, 1, 0, WD_D, DA_D, 2'b10, 1);
    addVec(1, 1, 0, WD_F, DA_F, 2'b11, 0, 1, '0, '0, 2'b00, 0);
    addVec(0, 0, 1, '0, '0, 2'b00, 0, 1, '0, '0, 2'b00, 0);

    repeat (3) @(posedge clk);
    #1;
    checkVal("reset wb_valid", 64'(wbValid), 64'd0);
    checkVal("reset wb_wd", 64'(wbWd), 64'd0);
    checkVal("reset wb_wdata", wbWdata, 64'd0);
    checkVal("reset wb_wreg", 64'(wbWreg), 64'd0);
    checkVal("reset mem_ready", 64'(memReady), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].flush, vecs[k].memValid, vecs[k].wbReady,
                    vecs[k].wd, vecs[k].wdata, vecs[k].wreg);
      @(posedge clk);
      #1;
      checkOutput(vecs[k], k);
    end

    // Async reset while both slots hold entries, checked before the next clock edge.
    applyStimulus(0, 1, 0, WD_A, DA_A, 2'b11);
    @(posedge clk);
    applyStimulus(0, 1, 0, WD_B, DA_B, 2'b11);
    @(posedge clk);
    #1;
    checkVal("full mem_ready", 64'(memReady), 64'd0);
    checkVal("full wb_valid", 64'(wbValid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    checkVal("async wb_valid", 64'(wbValid), 64'd0);
    checkVal("async wb_wreg", 64'(wbWreg), 64'd0);
    checkVal("async mem_ready", 64'(memReady), 64'd1);
    applyStimulus(0, 0, 1, '0, '0, 2'b00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkVal("post-reset wb_valid", 64'(wbValid), 64'd0);

`ifdef MEM_WB_STALL_CNT_EN
    checkVal("stall_cnt after reset", 64'(stallCnt), 64'd0);
    applyStimulus(0, 1, 0, WD_A, DA_A, 2'b11);
    repeat (22) @(posedge clk);
    #1;
    checkVal("stall_cnt saturated", 64'(stallCnt), 64'hF);
    applyStimulus(1, 1, 0, WD_F, DA_F, 2'b11);
    @(posedge clk);
    #1;
    checkVal("stall_cnt after flush", 64'(stallCnt), 64'hF);
    checkVal("flush wb_valid", 64'(wbValid), 64'd0);
    applyStimulus(0, 0, 1, '0, '0, 2'b00);
    rst = 1'b0;
    #1;
    checkVal("stall_cnt after rst", 64'(stallCnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM->WB pipeline register for the next-generation core; replaces the fixed single-port MEM/WB latch.
- Carries NUM_CH register-write channels per instruction group, with a valid/ready handshake, a 2-entry skid buffer, a synchronous flush, and same-destination conflict masking.
- Sits between the memory stage and the write-back/regfile write ports.

Parameters:
- DATA_W, 32, width of one write-data field
- ADDR_W, 5, width of one register address field
- NUM_CH, 2, number of write channels per entry (1..4); channel NUM_CH-1 is youngest in program order
- CNT_W, 32, stall counter width (optional feature only)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- flush  in  1  synchronous flush; drops every held entry
- mem_valid  in  1  MEM presents an entry
- mem_ready  out  1  block can accept an entry this cycle
- mem_wd  in  NUM_CH*ADDR_W  destination registers; channel i occupies bits [i*ADDR_W +: ADDR_W]
- mem_wdata  in  NUM_CH*DATA_W  write data, packed per channel
- mem_wreg  in  NUM_CH  per-channel write enables
- wb_valid  out  1  entry presented to WB
- wb_ready  in  1  WB consumes the presented entry
- wb_wd  out  NUM_CH*ADDR_W  destinations of the head entry
- wb_wdata  out  NUM_CH*DATA_W  data of the head entry
- wb_wreg  out  NUM_CH  write enables of the head entry, gated with wb_valid
- stall_cnt  out  CNT_W  back-pressure cycle count; present only with MEM_WB_STALL_CNT_EN

Behaviour:
- Reset (rst=0, asynchronous): main and skid slots are invalid, and all of their fields are 0. Outputs: wb_valid=0, wb_wd=0, wb_wdata=0, wb_wreg=0, mem_ready=1.
- Storage: a main slot drives the wb_* outputs; a skid slot catches an entry when WB stalls.
- mem_ready = !skid_valid. It is a registered condition with no combinational path from wb_ready.
- Accept: a transfer happens when mem_valid && mem_ready. The entry reaches wb_* on the next cycle (latency 1); sustained throughput is 1 entry per cycle.
- Consume: happens when wb_valid && wb_ready.
- Per-cycle update, with main empty or consumed:
  - If skid is valid, skid moves to main.
  - Otherwise, an accepted entry loads into main.
  - Otherwise, main becomes invalid.
- Main held (valid and not consumed) and an entry accepted: the entry goes to skid.
- Skid valid and main consumed, with a simultaneous accept: skid moves to main, and the new entry goes to skid. The FIFO order is preserved.
- Full (both slots valid): mem_ready=0, and any mem_* inputs are ignored.
- Conflict masking, applied at capture: for channels i<j with mem_wreg[i]=mem_wreg[j]=1 and mem_wd[i]==mem_wd[j], the stored wreg[i] is 0. The younger channel wins, so WB never performs a double write.
- Register 0 is not special-cased; WB handles it.
- wb_wreg[i] = stored_wreg[i] & wb_valid. A bubble never writes.
- Flush (synchronous, highest priority after reset):
  - Both slots become invalid, and their stored wreg bits become 0. Address and data fields are don't-care.
  - A simultaneous mem_valid is dropped even though mem_ready=1 was shown.
  - mem_ready=1 on the following cycle.
- Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
- No X propagation: wb_wreg is never X after reset.

Optional Feature:
- Macro: MEM_WB_STALL_CNT_EN.
- Defined: the stall_cnt port exists.
  - It increments by 1 every cycle with mem_valid && !mem_ready.
  - It saturates at all-ones.
  - It resets to 0 on rst, and is not cleared by flush.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then stream: rst low 3 cycles, then mem_valid=1 with wd={5'd2,5'd1}, wdata={32'hB,32'hA}, wreg=2'b11 and wb_ready=1. Required: wb_valid=1 the next cycle with the same values; mem_ready stays 1; 4 back-to-back entries emerge in 4 consecutive cycles.
- Back-pressure: wb_ready=0 while entries A, B, C are offered. Required: A held in main, B in skid, mem_ready=0, C held by MEM. When wb_ready=1: A, B, C appear in order on consecutive cycles, with no loss or duplication.
- Conflict: wd={5'd7,5'd7}, wreg=2'b11, wdata={32'h22,32'h11}. Required: wb_wreg=2'b10 and wb_wdata[63:32]=32'h22. With wd={5'd7,5'd8}: wb_wreg=2'b11.
- Flush while full: both slots valid and mem_valid=1 with flush=1. Required: the next cycle has wb_valid=0, wb_wreg=0, mem_ready=1, and the offered entry never appears.
- Async reset mid-stall: both slots full, rst driven low between clock edges. Required: wb_valid and wb_wreg are 0 before the next edge, and mem_ready=1.
- With MEM_WB_STALL_CNT_EN and CNT_W=4: hold mem_valid=1, mem_ready=0 for 20 cycles. Required: stall_cnt=4'hF (saturated). After a flush it is still 4'hF; after rst it is 0.
